// File: rtl/quad_decoder_pkg.sv
// quad_pkg: shared phase encoding, FSM states and gray-sequence helper for the quadrature decoder.
package quad_pkg;
    typedef logic [1:0] phase_t;
    localparam phase_t PH0 = 2'b00;
    localparam phase_t PH1 = 2'b01;
    localparam phase_t PH2 = 2'b11;
    localparam phase_t PH3 = 2'b10;
    typedef enum logic {INIT, RUN} qstate_t;
    function automatic phase_t next_fwd(input phase_t p);
        return p == PH0 ? PH1 : p == PH1 ? PH2 : p == PH2 ? PH3 : PH0;
    endfunction
endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder channels and error clear in, step/direction/error out.
interface quad_decoder_if;
    logic a_in;
    logic b_in;
    logic err_clr;
    logic step;
    logic up;
    logic err;
    modport master(output a_in, b_in, err_clr, input step, up, err);
    modport slave(input a_in, b_in, err_clr, output step, up, err);
endinterface

// File: rtl/quad_decoder_chan_filter.sv
// chan_filter: 2-FF synchroniser plus hold-time debounce for one encoder channel.
module chan_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic load,
    output logic s2,
    output logic filt
);
    localparam int FW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
    logic s1;
    logic [FW-1:0] fcnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            fcnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // load forces the accepted level straight from the synchroniser at start-up
            if (load) begin
                filt <= s2;
                fcnt <= '0;
            end else if (s2 != filt) begin
                if (fcnt == FW'(FILT_LEN - 1)) begin
                    filt <= s2;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: debounced quadrature decode into one-cycle detent steps with direction and sticky error.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILT_LEN       = 4,
    parameter int CNT_PER_DETENT = 4
) (
    input  logic clk,
    input  logic rst_n,
    quad_decoder_if.slave bus
);
    localparam int AW = $clog2(CNT_PER_DETENT) + 2;
    localparam logic signed [AW-1:0] DET = AW'(CNT_PER_DETENT);
    qstate_t state;
    logic [1:0] icnt;
    phase_t prev, cur, sync;
    logic signed [AW-1:0] acc, acc_nx;
    logic fwd, rev, bad, load;
    assign load = state == INIT && icnt == 2'd2;
    chan_filter #(.FILT_LEN(FILT_LEN)) u_a (
        .clk(clk), .rst_n(rst_n), .raw(bus.a_in), .load(load), .s2(sync[1]), .filt(cur[1])
    );
    chan_filter #(.FILT_LEN(FILT_LEN)) u_b (
        .clk(clk), .rst_n(rst_n), .raw(bus.b_in), .load(load), .s2(sync[0]), .filt(cur[0])
    );
    // one-bit moves are always fwd or rev in gray order; anything else changed both bits
    always_comb begin
        fwd    = cur == next_fwd(prev);
        rev    = prev == next_fwd(cur);
        bad    = cur != prev && !fwd && !rev;
        acc_nx = fwd ? acc + 1'b1 : rev ? acc - 1'b1 : acc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            icnt     <= 2'd0;
            prev     <= PH0;
            acc      <= '0;
            bus.step <= 1'b0;
            bus.up   <= 1'b1;
            bus.err  <= 1'b0;
        end else begin
            bus.step <= 1'b0;
            bus.err  <= (state == RUN && bad) || (bus.err && !bus.err_clr);
            if (state == INIT) begin
                icnt <= icnt + 1'b1;
                if (load) begin
                    prev  <= sync;
                    state <= RUN;
                end
            end else begin
                prev <= cur;
                if (bad) begin
                    acc <= '0;
                end else if (acc_nx == DET || acc_nx == -DET) begin
                    acc      <= '0;
                    bus.step <= 1'b1;
                    bus.up   <= acc_nx == DET;
                end else begin
                    acc <= acc_nx;
                end
            end
        end
    end
endmodule
